// File: rtl/mem_wb_elastic_stage.sv
// MEM->WB pipeline stage: two-entry elastic buffer (main + skid) that forms the
// final register-file write and a forwarding tap, with flush and load extension.
module mem_wb_elastic_stage #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            em_valid,
    output logic            em_ready,
    input  logic            em_memtoreg,
    input  logic            em_regwrite,
    input  logic [RD_W-1:0] em_rd,
    input  logic [2:0]      em_funct3,
    input  logic [XLEN-1:0] em_result,
    input  logic [XLEN-1:0] em_readdata,
    input  logic            wb_ready,
    output logic            wb_valid,
    output logic            wb_regwrite,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_wdata,
    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    typedef struct packed {
        logic            regwrite;
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] wdata;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t cap_c;
    logic   accept_c;
    logic   retire_c;
    logic [XLEN-1:0] ext_data_c;

    assign accept_c = em_valid & em_ready;
    assign retire_c = wb_valid & wb_ready;

    // Load result extension; width casts make the 32-bit cases pass through at XLEN=32.
    always_comb begin
        ext_data_c = em_readdata;
        unique case (em_funct3)
            3'b000:  ext_data_c = XLEN'($signed(em_readdata[7:0]));
            3'b001:  ext_data_c = XLEN'($signed(em_readdata[15:0]));
            3'b010:  ext_data_c = XLEN'($signed(em_readdata[31:0]));
            3'b100:  ext_data_c = XLEN'(em_readdata[7:0]);
            3'b101:  ext_data_c = XLEN'(em_readdata[15:0]);
            3'b110:  ext_data_c = XLEN'(em_readdata[31:0]);
            default: ext_data_c = em_readdata;
        endcase
    end

    // Entry is fully formed at capture; x0 writes are suppressed here.
    always_comb begin
        cap_c.regwrite = em_regwrite & (em_rd != '0);
        cap_c.rd       = em_rd;
        cap_c.wdata    = em_memtoreg ? ext_data_c : em_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            em_ready <= 1'b1;
            wb_valid <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            // Any same-cycle retire has already been consumed downstream.
            state           <= EMPTY;
            em_ready        <= 1'b1;
            wb_valid        <= 1'b0;
            main_q.regwrite <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept_c) begin
                        main_q   <= cap_c;
                        wb_valid <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (accept_c && retire_c) begin
                        main_q <= cap_c;
                    end else if (accept_c) begin
                        skid_q   <= cap_c;
                        state    <= TWO;
                        em_ready <= 1'b0;
                    end else if (retire_c) begin
                        state           <= EMPTY;
                        wb_valid        <= 1'b0;
                        main_q.regwrite <= 1'b0;
                    end
                end
                TWO: begin
                    if (retire_c) begin
                        main_q   <= skid_q;
                        state    <= ONE;
                        em_ready <= 1'b1;
                    end
                end
                default: begin
                    state           <= EMPTY;
                    em_ready        <= 1'b1;
                    wb_valid        <= 1'b0;
                    main_q.regwrite <= 1'b0;
                end
            endcase
        end
    end

    assign wb_regwrite = main_q.regwrite;
    assign wb_rd       = main_q.rd;
    assign wb_wdata    = main_q.wdata;
    assign fwd_valid   = main_q.regwrite;
    assign fwd_rd      = main_q.rd;
    assign fwd_data    = main_q.wdata;

endmodule

// File: tb/tb_mem_wb_elastic_stage.sv
// Directed bench for mem_wb_elastic_stage (XLEN=64): extension, elastic ordering,
// flush and async reset, checked with immediate assertions.
module tb_mem_wb_elastic_stage;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            em_valid;
    logic            em_ready;
    logic            em_memtoreg;
    logic            em_regwrite;
    logic [RD_W-1:0] em_rd;
    logic [2:0]      em_funct3;
    logic [XLEN-1:0] em_result;
    logic [XLEN-1:0] em_readdata;
    logic            wb_ready;
    logic            wb_valid;
    logic            wb_regwrite;
    logic [RD_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_wdata;
    logic            fwd_valid;
    logic [RD_W-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_data;

    int errors = 0;
    int checks = 0;

    mem_wb_elastic_stage #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .em_valid(em_valid), .em_ready(em_ready), .em_memtoreg(em_memtoreg),
        .em_regwrite(em_regwrite), .em_rd(em_rd), .em_funct3(em_funct3),
        .em_result(em_result), .em_readdata(em_readdata),
        .wb_ready(wb_ready), .wb_valid(wb_valid), .wb_regwrite(wb_regwrite),
        .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [RD_W-1:0] rd, input logic [XLEN-1:0] res);
        em_valid    = 1'b1;
        em_memtoreg = 1'b0;
        em_regwrite = 1'b1;
        em_rd       = rd;
        em_result   = res;
    endtask

    task automatic load(input logic [2:0] f3, input logic [XLEN-1:0] rdata);
        em_valid    = 1'b1;
        em_memtoreg = 1'b1;
        em_regwrite = 1'b1;
        em_rd       = 5'd7;
        em_funct3   = f3;
        em_readdata = rdata;
        em_result   = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; em_valid = 1'b0; em_memtoreg = 1'b0;
        em_regwrite = 1'b0; em_rd = '0; em_funct3 = 3'b000; em_result = '0;
        em_readdata = '0; wb_ready = 1'b0;
        #8;
        chk("rst_em_ready", 64'(em_ready), 64'd1);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_regwrite", 64'(wb_regwrite), 64'd0);
        chk("rst_wb_rd", 64'(wb_rd), 64'd0);
        chk("rst_wb_wdata", wb_wdata, 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        #4 reset = 1'b0;

        // Single ALU write, one-cycle latency
        alu(5'd5, 64'h1234);
        wb_ready = 1'b1;
        tick();
        chk("alu_wb_valid", 64'(wb_valid), 64'd1);
        chk("alu_wb_rd", 64'(wb_rd), 64'd5);
        chk("alu_wb_wdata", wb_wdata, 64'h1234);
        chk("alu_wb_regwrite", 64'(wb_regwrite), 64'd1);
        chk("alu_fwd_rd", 64'(fwd_rd), 64'd5);
        chk("alu_fwd_data", fwd_data, 64'h1234);
        chk("alu_em_ready", 64'(em_ready), 64'd1);

        // Load extension, streaming with wb_ready=1
        load(3'b000, 64'h0000_0000_00F0_8081); tick();
        chk("lb", wb_wdata, 64'hFFFF_FFFF_FFFF_FF81);
        load(3'b100, 64'h0000_0000_00F0_8081); tick();
        chk("lbu", wb_wdata, 64'h0000_0000_0000_0081);
        load(3'b001, 64'h0000_0000_00F0_8081); tick();
        chk("lh", wb_wdata, 64'hFFFF_FFFF_FFFF_8081);
        load(3'b110, 64'h0000_0000_00F0_8081); tick();
        chk("lwu", wb_wdata, 64'h0000_0000_00F0_8081);
        load(3'b101, 64'h0000_0000_00F0_8081); tick();
        chk("lhu", wb_wdata, 64'h0000_0000_0000_8081);
        load(3'b010, 64'h1234_5678_8000_0001); tick();
        chk("lw_neg", wb_wdata, 64'hFFFF_FFFF_8000_0001);
        load(3'b110, 64'h1234_5678_8000_0001); tick();
        chk("lwu_hi", wb_wdata, 64'h0000_0000_8000_0001);
        load(3'b011, 64'h1234_5678_8000_0001); tick();
        chk("ld", wb_wdata, 64'h1234_5678_8000_0001);
        load(3'b111, 64'hFEDC_BA98_7654_3210); tick();
        chk("rsvd", wb_wdata, 64'hFEDC_BA98_7654_3210);
        chk("load_regwrite", 64'(wb_regwrite), 64'd1);

        // x0 destination flows but does not write
        alu(5'd0, 64'hDEAD); tick();
        chk("x0_wb_valid", 64'(wb_valid), 64'd1);
        chk("x0_wb_regwrite", 64'(wb_regwrite), 64'd0);
        chk("x0_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("x0_wb_wdata", wb_wdata, 64'hDEAD);
        em_valid = 1'b0; tick();
        chk("drain_wb_valid", 64'(wb_valid), 64'd0);
        chk("drain_regwrite", 64'(wb_regwrite), 64'd0);

        // Back-to-back A,B,C with downstream stalled
        wb_ready = 1'b0;
        alu(5'd1, 64'hA); tick();
        chk("bb_a_main", 64'(wb_rd), 64'd1);
        chk("bb_one_ready", 64'(em_ready), 64'd1);
        alu(5'd2, 64'hB); tick();
        chk("bb_two_ready", 64'(em_ready), 64'd0);
        chk("bb_two_main", 64'(wb_rd), 64'd1);
        alu(5'd3, 64'hC); tick();
        chk("bb_c_held_ready", 64'(em_ready), 64'd0);
        chk("bb_c_held_main", wb_wdata, 64'hA);
        wb_ready = 1'b1; tick();
        chk("bb_ret_b_rd", 64'(wb_rd), 64'd2);
        chk("bb_ret_b_data", wb_wdata, 64'hB);
        chk("bb_ret_b_ready", 64'(em_ready), 64'd1);
        tick();
        chk("bb_ret_c_rd", 64'(wb_rd), 64'd3);
        chk("bb_ret_c_data", wb_wdata, 64'hC);
        em_valid = 1'b0; tick();
        chk("bb_empty", 64'(wb_valid), 64'd0);

        // Flush in TWO: main retires on the flush edge, skid is dropped
        wb_ready = 1'b0;
        alu(5'd4, 64'hD); tick();
        alu(5'd6, 64'hE); tick();
        chk("fl_two_ready", 64'(em_ready), 64'd0);
        em_valid = 1'b0; flush = 1'b1; wb_ready = 1'b1;
        #1;
        chk("fl_main_visible", 64'(wb_rd), 64'd4);
        chk("fl_main_valid", 64'(wb_valid), 64'd1);
        tick();
        flush = 1'b0;
        chk("fl_wb_valid", 64'(wb_valid), 64'd0);
        chk("fl_em_ready", 64'(em_ready), 64'd1);
        chk("fl_regwrite", 64'(wb_regwrite), 64'd0);
        tick();
        chk("fl_skid_dropped", 64'(wb_valid), 64'd0);

        // Flush drops a same-cycle accept
        alu(5'd9, 64'h99); flush = 1'b1; tick();
        flush = 1'b0; em_valid = 1'b0;
        chk("fl_accept_dropped", 64'(wb_valid), 64'd0);
        tick();
        chk("fl_accept_still_empty", 64'(wb_valid), 64'd0);

        // Asynchronous reset while in TWO
        wb_ready = 1'b0;
        alu(5'd10, 64'h10); tick();
        alu(5'd11, 64'h11); tick();
        em_valid = 1'b0;
        chk("ar_two_ready", 64'(em_ready), 64'd0);
        #2 reset = 1'b1;
        #1;
        chk("ar_wb_valid", 64'(wb_valid), 64'd0);
        chk("ar_em_ready", 64'(em_ready), 64'd1);
        chk("ar_regwrite", 64'(wb_regwrite), 64'd0);
        chk("ar_wdata", wb_wdata, 64'd0);
        #1 reset = 1'b0;
        wb_ready = 1'b1;
        tick();
        chk("ar_after_valid", 64'(wb_valid), 64'd0);
        chk("ar_after_ready", 64'(em_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
